// File: rtl/adder_bcd_display.sv
// adder_bcd_display
// Adds two WIDTH-bit operands plus carry-in, converts the registered sum to
// BCD with a one-bit-per-clock shift-add-3 engine, and drives DIGITS
// active-low seven-segment displays (gfedcba). start/busy/done handshake.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module adder_bcd_display #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic                  cin,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH:0]        sum,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int SW = WIDTH + 1;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(SW);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   shift_q;
    logic [BW-1:0]   bcd_q;
    logic [CW-1:0]   cnt_q;
    logic            lost_q;

    logic [SW-1:0]   sum_in;
    logic [BW-1:0]   bcd_adj;
    logic [BW-1:0]   bcd_shl;
    logic [SW-1:0]   shift_shl;
    logic            shift_out;
    logic [7*DIGITS-1:0] seg_nxt;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0011000;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    // Display shown after reset: a single '0' on digit 0; upper digits
    // show '0' too unless leading zeros are blanked.
    function automatic logic [7*DIGITS-1:0] reset_pattern();
        logic [7*DIGITS-1:0] r;
        r = '1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
`ifdef LEADING_ZERO_BLANK_EN
            if (k == 0) r[7*k +: 7] = SEG_ZERO;
`else
            r[7*k +: 7] = SEG_ZERO;
`endif
        end
        return r;
    endfunction

    assign sum_in    = {1'b0, a} + {1'b0, b} + SW'(cin);
    assign busy      = (state != IDLE);
    assign shift_shl = {shift_q[SW-2:0], 1'b0};
    // Top bit of the adjusted BCD leaves the accumulator; the sum's MSB enters.
    assign {shift_out, bcd_shl} = {bcd_adj, shift_q[SW-1]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONV;
            CONV:    if (cnt_q == LAST) state_nxt = SHOW;
            SHOW:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction of every BCD nibble >= 5 ahead of the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    // Segment patterns from the converted BCD value, scanned from the top digit
    always_comb begin
        logic        above_nz;
        logic [3:0]  nib;
        int unsigned idx;
        seg_nxt  = '1;
        above_nz = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            idx = DIGITS - 1 - k;
            nib = bcd_q[4*idx +: 4];
            if (nib != 4'd0) above_nz = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
            if (above_nz || idx == 0) seg_nxt[7*idx +: 7] = seg_code(nib);
`else
            seg_nxt[7*idx +: 7] = seg_code(nib);
`endif
            if (lost_q) seg_nxt[7*idx +: 7] = SEG_DASH;
        end
    end

    // Operand capture, conversion datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sum      <= '0;
            overflow <= 1'b0;
            seg      <= reset_pattern();
            done     <= 1'b0;
            shift_q  <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            lost_q   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sum     <= sum_in;
                        shift_q <= sum_in;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        lost_q  <= 1'b0;
                    end
                end
                CONV: begin
                    shift_q <= shift_shl;
                    bcd_q   <= bcd_shl;
                    cnt_q   <= cnt_q + CW'(1);
                    lost_q  <= lost_q | shift_out;
                end
                SHOW: begin
                    seg      <= seg_nxt;
                    overflow <= lost_q;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_bcd_display.sv
// tb_adder_bcd_display
// Randomised and directed checks of adder_bcd_display against a decimal
// reference model (WIDTH=8 with DIGITS=3, plus a DIGITS=2 instance for
// overflow). Honours LEADING_ZERO_BLANK_EN when defined.
module tb_adder_bcd_display;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0, start = 1'b0;
    logic         busy, done, ovf;
    logic [W:0]   sum;
    logic [20:0]  seg;

    logic [W-1:0] a2 = '0, b2 = '0;
    logic         cin2 = 1'b0, start2 = 1'b0;
    logic         busy2, done2, ovf2;
    logic [W:0]   sum2;
    logic [13:0]  seg2;

    int checks = 0;
    int errors = 0;

    adder_bcd_display #(.WIDTH(W), .DIGITS(3)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .cin(cin), .start(start),
        .busy(busy), .done(done), .sum(sum), .overflow(ovf), .seg(seg)
    );

    adder_bcd_display #(.WIDTH(W), .DIGITS(2)) dut2 (
        .clk(clk), .reset(reset), .a(a2), .b(b2), .cin(cin2), .start(start2),
        .busy(busy2), .done(done2), .sum(sum2), .overflow(ovf2), .seg(seg2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] digit_code(input int unsigned d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0011000;
        endcase
    endfunction

    // Decimal model: digits by division, dashes when the value does not fit
    function automatic logic [20:0] model_seg(input int unsigned s, input int unsigned nd);
        int unsigned lim = 1;
        int unsigned p = 1;
        logic [20:0] r = '1;
        for (int i = 0; i < nd; i++) lim *= 10;
        if (s >= lim) begin
            for (int i = 0; i < 3; i++) r[7*i +: 7] = 7'b0111111;
            return r;
        end
        for (int i = 0; i < 3; i++) begin
            if (i < nd) begin
                r[7*i +: 7] = digit_code((s / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
                if (i > 0 && s < p) r[7*i +: 7] = 7'b1111111;
`endif
            end
            p *= 10;
        end
        return r;
    endfunction

    task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                         output int unsigned s_exp);
        a = ai; b = bi; cin = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s_exp = int'(ai) + int'(bi) + int'(ci);
        check("busy_accept", 64'(busy), 64'd1);
        check("done_accept", 64'(done), 64'd0);
        check("sum_accept", 64'(sum), 64'(s_exp));
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    endtask

    task automatic complete(input int unsigned s_exp, input bit repulse);
        for (int i = 0; i < W + 1; i++) begin
            if (repulse && i == 2) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check("done_early", 64'(done), 64'd0);
            check("busy_conv", 64'(busy), 64'd1);
        end
        @(posedge clk); #1;
        check("done_pulse", 64'(done), 64'd1);
        check("busy_done", 64'(busy), 64'd0);
        check("seg", 64'(seg), 64'(model_seg(s_exp, 3)));
        check("overflow", 64'(ovf), 64'(s_exp >= 1000));
        check("sum_hold", 64'(sum), 64'(s_exp));
    endtask

    task automatic idle_after;
        @(posedge clk); #1;
        check("done_one_cycle", 64'(done), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
    endtask

    task automatic op2(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci);
        int unsigned s;
        logic [20:0] m;
        a2 = ai; b2 = bi; cin2 = ci; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        s = int'(ai) + int'(bi) + int'(ci);
        m = model_seg(s, 2);
        repeat (W + 1) @(posedge clk);
        #1 check("d2_done_early", 64'(done2), 64'd0);
        @(posedge clk); #1;
        check("d2_done", 64'(done2), 64'd1);
        check("d2_sum", 64'(sum2), 64'(s));
        check("d2_overflow", 64'(ovf2), 64'(s >= 100));
        check("d2_seg", 64'(seg2), 64'(m[13:0]));
    endtask

    initial begin
        int unsigned s;
        bit saw_done;
        logic [20:0] rst_pat;
        logic [W-1:0] ra, rb;

        rst_pat = model_seg(0, 3);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_overflow", 64'(ovf), 64'd0);
        check("rst_seg", 64'(seg), 64'(rst_pat));
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases; the first re-pulses start mid-conversion
        issue(8'd200, 8'd55, 1'b1, s); complete(s, 1'b1); idle_after();
        issue(8'd255, 8'd255, 1'b1, s); complete(s, 1'b0); idle_after();
        issue(8'd0, 8'd0, 1'b0, s); complete(s, 1'b0); idle_after();
        issue(8'd3, 8'd4, 1'b0, s); complete(s, 1'b0); idle_after();

        // Back-to-back: start during the done cycle is accepted
        issue(8'd10, 8'd20, 1'b0, s); complete(s, 1'b0);
        issue(8'd99, 8'd1, 1'b1, s); complete(s, 1'b0); idle_after();

        // Randomised operations, occasionally back-to-back
        for (int n = 0; n < 24; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (n % 6 == 0) ra = '1;
            issue(ra, rb, 1'($urandom), s);
            complete(s, 1'($urandom));
            if ($urandom_range(0, 1) == 0) idle_after();
        end
        idle_after();

        // Reset in the 4th conversion cycle aborts the operation
        issue(8'd123, 8'd45, 1'b0, s);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_sum", 64'(sum), 64'd0);
        check("abort_seg", 64'(seg), 64'(rst_pat));
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (W + 4) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);
        check("abort_seg_hold", 64'(seg), 64'(rst_pat));

        // Two-digit instance: overflow shows dashes, sum stays exact
        op2(8'd60, 8'd40, 1'b0);
        op2(8'd99, 8'd0, 1'b0);
        op2(8'd5, 8'd4, 1'b0);
        for (int n = 0; n < 5; n++) op2(W'($urandom), W'($urandom_range(0, 60)), 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
